// File: rtl/mempool_l2_interleaver.sv
// L2 front end: word-interleaves NumPorts request streams over NumBanks single-port SRAMs,
// arbitrates each bank round-robin and returns fixed-latency, in-order responses per port.
module mempool_l2_interleaver #(
    parameter int unsigned          NumPorts   = 2,
    parameter int unsigned          NumBanks   = 4,
    parameter int unsigned          DataWidth  = 64,
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          BankWords  = 1024,
    parameter int unsigned          MemLatency = 1,
    parameter logic [AddrWidth-1:0] BaseAddr   = 32'h8000_0000,
    localparam int unsigned         StrbWidth  = DataWidth / 8,
    localparam int unsigned         RowWidth   = (BankWords > 1) ? $clog2(BankWords) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             req_i,
    output logic [NumPorts-1:0]             gnt_o,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    input  logic [NumPorts*StrbWidth-1:0]   strb_i,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [NumPorts*DataWidth-1:0]   rdata_o,
    output logic [NumPorts-1:0]             rerr_o,
    output logic [NumBanks-1:0]             bank_req_o,
    output logic [NumBanks-1:0]             bank_we_o,
    output logic [NumBanks*RowWidth-1:0]    bank_addr_o,
    output logic [NumBanks*DataWidth-1:0]   bank_wdata_o,
    output logic [NumBanks*StrbWidth-1:0]   bank_be_o,
    input  logic [NumBanks*DataWidth-1:0]   bank_rdata_i
);

    localparam int unsigned OffBits     = $clog2(StrbWidth);
    localparam int unsigned BankBits    = $clog2(NumBanks);
    localparam int unsigned BankIdW     = (NumBanks > 1) ? BankBits : 1;
    localparam int unsigned PortIdW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [63:0] WindowBytes = 64'(NumBanks) * 64'(BankWords) * 64'(StrbWidth);
    localparam int unsigned Last        = MemLatency - 1;

    logic [AddrWidth-1:0] off      [NumPorts];
    logic [AddrWidth-1:0] word     [NumPorts];
    logic [BankIdW-1:0]   p_bank   [NumPorts];
    logic [RowWidth-1:0]  p_row    [NumPorts];
    logic [NumPorts-1:0]  p_inrange;

    logic [NumBanks-1:0]  win_vld;
    logic [PortIdW-1:0]   win_port [NumBanks];
    logic [PortIdW-1:0]   rr_q     [NumBanks];

    logic [MemLatency-1:0] bp_vld  [NumBanks];
    logic [MemLatency-1:0] bp_we   [NumBanks];
    logic [PortIdW-1:0]    bp_port [NumBanks][MemLatency];
    logic [MemLatency-1:0] op_vld  [NumPorts];

    logic rst_q;
    logic active;

    // Nothing is accepted while in reset or on the first cycle out of it.
    assign active = !rst_i && !rst_q;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            off[p]       = addr_i[p*AddrWidth +: AddrWidth] - BaseAddr;
            word[p]      = off[p] >> OffBits;
            p_bank[p]    = BankIdW'(word[p] & AddrWidth'(NumBanks - 1));
            p_row[p]     = RowWidth'(word[p] >> BankBits);
            p_inrange[p] = 64'(off[p]) < WindowBytes;
        end
    end

    // Scan downward so the candidate nearest at/after the pointer is assigned last and wins.
    always_comb begin
        win_vld = '0;
        for (int b = 0; b < NumBanks; b++) begin
            win_port[b] = '0;
            for (int i = NumPorts - 1; i >= 0; i--) begin
                int idx;
                idx = int'(rr_q[b]) + i;
                if (idx >= int'(NumPorts)) idx = idx - int'(NumPorts);
                if (req_i[idx] && p_inrange[idx] && (p_bank[idx] == BankIdW'(b))) begin
                    win_vld[b]  = 1'b1;
                    win_port[b] = PortIdW'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_o        = '0;
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        if (active) begin
            for (int p = 0; p < NumPorts; p++) begin
                if (req_i[p] && !p_inrange[p]) gnt_o[p] = 1'b1;
            end
            for (int b = 0; b < NumBanks; b++) begin
                if (win_vld[b]) begin
                    gnt_o[win_port[b]]                        = 1'b1;
                    bank_req_o[b]                             = 1'b1;
                    bank_we_o[b]                              = we_i[win_port[b]];
                    bank_addr_o[b*RowWidth +: RowWidth]       = p_row[win_port[b]];
                    bank_wdata_o[b*DataWidth +: DataWidth]    = wdata_i[win_port[b]*DataWidth +: DataWidth];
                    bank_be_o[b*StrbWidth +: StrbWidth]       = strb_i[win_port[b]*StrbWidth +: StrbWidth];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        rst_q <= rst_i;
        if (rst_i) begin
            for (int b = 0; b < NumBanks; b++) begin
                rr_q[b]   <= '0;
                bp_vld[b] <= '0;
                bp_we[b]  <= '0;
                for (int k = 0; k < MemLatency; k++) bp_port[b][k] <= '0;
            end
            for (int p = 0; p < NumPorts; p++) op_vld[p] <= '0;
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (active && win_vld[b]) begin
                    rr_q[b] <= (win_port[b] == PortIdW'(NumPorts - 1)) ? '0 : win_port[b] + 1'b1;
                end
                for (int k = Last; k > 0; k--) begin
                    bp_vld[b][k]  <= bp_vld[b][k-1];
                    bp_we[b][k]   <= bp_we[b][k-1];
                    bp_port[b][k] <= bp_port[b][k-1];
                end
                bp_vld[b][0]  <= active && win_vld[b];
                bp_we[b][0]   <= we_i[win_port[b]];
                bp_port[b][0] <= win_port[b];
            end
            for (int p = 0; p < NumPorts; p++) begin
                for (int k = Last; k > 0; k--) op_vld[p][k] <= op_vld[p][k-1];
                op_vld[p][0] <= active && req_i[p] && !p_inrange[p];
            end
        end
    end

    // Each port is granted at most once per cycle, so at most one source drives each port slot.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        rerr_o   = '0;
        if (!rst_i) begin
            for (int b = 0; b < NumBanks; b++) begin
                if (bp_vld[b][Last]) begin
                    rvalid_o[bp_port[b][Last]] = 1'b1;
                    if (!bp_we[b][Last]) begin
                        rdata_o[bp_port[b][Last]*DataWidth +: DataWidth] =
                            bank_rdata_i[b*DataWidth +: DataWidth];
                    end
                end
            end
            for (int p = 0; p < NumPorts; p++) begin
                if (op_vld[p][Last]) begin
                    rvalid_o[p] = 1'b1;
                    rerr_o[p]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mempool_l2_interleaver.sv
// Directed bench for mempool_l2_interleaver with a behavioural SRAM model per bank (read latency 3).
module tb_mempool_l2_interleaver;

    localparam int NP = 2, NB = 4, DW = 64, AW = 32, BW = 1024, LAT = 3, SW = 8, RW = 10;
    localparam logic [DW-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]    req, gnt, we, rvalid, rerr;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata, rdata;
    logic [NP*SW-1:0] strb;
    logic [NB-1:0]    bank_req, bank_we;
    logic [NB*RW-1:0] bank_addr;
    logic [NB*DW-1:0] bank_wdata, bank_rdata;
    logic [NB*SW-1:0] bank_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mempool_l2_interleaver #(
        .NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .AddrWidth(AW),
        .BankWords(BW), .MemLatency(LAT), .BaseAddr(32'h8000_0000)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .wdata_i(wdata), .strb_i(strb),
        .rvalid_o(rvalid), .rdata_o(rdata), .rerr_o(rerr),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
        .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata)
    );

    function automatic logic [DW-1:0] init_val(int b, int r);
        return 64'hA5A5_0000_0000_0000 | (64'(b) << 32) | 64'(r);
    endfunction

    // SRAM model: rows preloaded with init_val during reset, reads returned LAT cycles after request.
    logic [DW-1:0] mem   [NB][BW];
    logic [DW-1:0] rpipe [NB][LAT];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (rst) begin
                for (int r = 0; r < BW; r++) mem[b][r] <= init_val(b, r);
            end else if (bank_req[b] && bank_we[b]) begin
                for (int i = 0; i < SW; i++)
                    if (bank_be[b*SW+i])
                        mem[b][bank_addr[b*RW +: RW]][i*8 +: 8] <= bank_wdata[b*DW + i*8 +: 8];
            end
            rpipe[b][0] <= (bank_req[b] && !bank_we[b]) ? mem[b][bank_addr[b*RW +: RW]] : JUNK;
            for (int k = 1; k < LAT; k++) rpipe[b][k] <= rpipe[b][k-1];
        end
    end

    always_comb begin
        bank_rdata = '0;
        for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = rpipe[b][LAT-1];
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        req[p] = r;
        we[p]  = w;
        addr[p*AW +: AW]  = a;
        wdata[p*DW +: DW] = d;
        strb[p*SW +: SW]  = s;
    endtask

    task automatic idle_all();
        req = '0; we = '0; addr = '0; wdata = '0; strb = '0;
    endtask

    function automatic logic [DW-1:0] rd(int p);
        return rdata[p*DW +: DW];
    endfunction

    function automatic logic [RW-1:0] baddr(int b);
        return bank_addr[b*RW +: RW];
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, ".gnt"}, gnt, '0);
        check_val({tag, ".bank_req"}, bank_req, '0);
        check_val({tag, ".rvalid"}, rvalid, '0);
        check_val({tag, ".rerr"}, rerr, '0);
        check_val({tag, ".rdata"}, rdata, '0);
    endtask

    // Step over the cycles between grant and response; nothing may respond early.
    task automatic skip_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            check_val({tag, ".early_rvalid"}, rvalid, '0);
            tick();
        end
    endtask

    localparam logic [1:0] CONF_GNT [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [1:0] CONF_RV  [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_all();
        drive(0, 1'b1, 1'b0, 32'h8000_0008, '0, 8'hFF);
        sample();
        check_quiet("in_reset");
        tick();
        rst = 1'b0;
        idle_all();
        sample();
        check_quiet("after_reset");
        tick();

        // write then read back through bank1 row0
        drive(0, 1'b1, 1'b1, 32'h8000_0008, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        sample();
        check_val("wr.gnt", gnt, 2'b01);
        check_val("wr.bank_req", bank_req, 4'b0010);
        check_val("wr.bank_we", bank_we, 4'b0010);
        check_val("wr.bank_addr", baddr(1), 10'd0);
        check_val("wr.bank_wdata", bank_wdata[1*DW +: DW], 64'hDEAD_BEEF_0000_0001);
        check_val("wr.bank_be", bank_be[1*SW +: SW], 8'hFF);
        tick();
        idle_all();
        skip_quiet("wr", LAT - 1);
        sample();
        check_val("wr.rvalid", rvalid, 2'b01);
        check_val("wr.rdata", rd(0), 64'h0);
        check_val("wr.rerr", rerr, 2'b00);
        tick();
        drive(0, 1'b1, 1'b0, 32'h8000_0008, '0, '0);
        sample();
        check_val("rd.gnt", gnt, 2'b01);
        check_val("rd.bank_req", bank_req, 4'b0010);
        check_val("rd.bank_we", bank_we, 4'b0000);
        tick();
        idle_all();
        skip_quiet("rd", LAT - 1);
        sample();
        check_val("rd.rvalid", rvalid, 2'b01);
        check_val("rd.rdata", rd(0), 64'hDEAD_BEEF_0000_0001);
        check_val("rd.rerr", rerr, 2'b00);
        tick();

        // both ports hammer bank2: grants alternate starting with port0
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                drive(0, 1'b1, 1'b0, 32'h8000_0010, '0, '0);
                drive(1, 1'b1, 1'b0, 32'h8000_0030, '0, '0);
            end else begin
                idle_all();
            end
            sample();
            check_val($sformatf("conf%0d.gnt", k), gnt, CONF_GNT[k]);
            check_val($sformatf("conf%0d.bank_req", k), bank_req, (k < 4) ? 4'b0100 : 4'b0000);
            if (k < 4) check_val($sformatf("conf%0d.row", k), baddr(2), (k % 2 == 0) ? 10'd0 : 10'd1);
            check_val($sformatf("conf%0d.rvalid", k), rvalid, CONF_RV[k]);
            if (CONF_RV[k] == 2'b01) check_val($sformatf("conf%0d.rdata0", k), rd(0), init_val(2, 0));
            if (CONF_RV[k] == 2'b10) check_val($sformatf("conf%0d.rdata1", k), rd(1), init_val(2, 1));
            tick();
        end

        // disjoint banks in one cycle, port1 writes low half only
        drive(0, 1'b1, 1'b0, 32'h8000_0000, '0, '0);
        drive(1, 1'b1, 1'b1, 32'h8000_0018, 64'h1111_2222_3333_4444, 8'h0F);
        sample();
        check_val("par.gnt", gnt, 2'b11);
        check_val("par.bank_req", bank_req, 4'b1001);
        check_val("par.bank_we", bank_we, 4'b1000);
        check_val("par.bank_be3", bank_be[3*SW +: SW], 8'h0F);
        check_val("par.bank_be0", bank_be[0*SW +: SW], 8'h00);
        check_val("par.bank_wdata3", bank_wdata[3*DW +: DW], 64'h1111_2222_3333_4444);
        tick();
        idle_all();
        skip_quiet("par", LAT - 1);
        sample();
        check_val("par.rvalid", rvalid, 2'b11);
        check_val("par.rdata0", rd(0), 64'hA5A5_0000_0000_0000);
        check_val("par.rdata1", rd(1), 64'h0);
        tick();
        drive(1, 1'b1, 1'b0, 32'h8000_0018, '0, '0);
        sample();
        check_val("merge.gnt", gnt, 2'b10);
        check_val("merge.bank_req", bank_req, 4'b1000);
        tick();
        idle_all();
        skip_quiet("merge", LAT - 1);
        sample();
        check_val("merge.rvalid", rvalid, 2'b10);
        check_val("merge.rdata1", rd(1), 64'hA5A5_0003_3333_4444);
        tick();

        // out of range: first byte past the window, and an address below the base
        drive(1, 1'b1, 1'b0, 32'h8000_8000, '0, '0);
        drive(0, 1'b1, 1'b1, 32'h7FFF_FFF8, 64'h55, 8'hFF);
        sample();
        check_val("oor.gnt", gnt, 2'b11);
        check_val("oor.bank_req", bank_req, 4'b0000);
        tick();
        idle_all();
        skip_quiet("oor", LAT - 1);
        sample();
        check_val("oor.rvalid", rvalid, 2'b11);
        check_val("oor.rerr", rerr, 2'b11);
        check_val("oor.rdata", rdata, '0);
        tick();

        // last in-range byte, low offset bits ignored
        drive(0, 1'b1, 1'b0, 32'h8000_7FFF, '0, '0);
        sample();
        check_val("top.gnt", gnt, 2'b01);
        check_val("top.bank_req", bank_req, 4'b1000);
        check_val("top.row", baddr(3), 10'd1023);
        tick();
        idle_all();
        skip_quiet("top", LAT - 1);
        sample();
        check_val("top.rvalid", rvalid, 2'b01);
        check_val("top.rerr", rerr, 2'b00);
        check_val("top.rdata", rd(0), 64'hA5A5_0003_0000_03FF);
        tick();

        // back-to-back reads across all banks from port0
        for (int k = 0; k < 8; k++) begin
            if (k < 4) drive(0, 1'b1, 1'b0, 32'h8000_0020 + 32'(8 * k), '0, '0);
            else idle_all();
            sample();
            check_val($sformatf("b2b%0d.gnt", k), gnt, (k < 4) ? 2'b01 : 2'b00);
            check_val($sformatf("b2b%0d.bank_req", k), bank_req, (k < 4) ? 4'(1 << k) : 4'b0000);
            check_val($sformatf("b2b%0d.rvalid", k), rvalid, (k >= 3 && k < 7) ? 2'b01 : 2'b00);
            if (k >= 3 && k < 7) check_val($sformatf("b2b%0d.rdata", k), rd(0), init_val(k - 3, 1));
            tick();
        end

        // reset with three reads in flight: none of them may respond
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 1'b0, 32'h8000_0000 + 32'(8 * k), '0, '0);
            sample();
            check_val($sformatf("flush%0d.gnt", k), gnt, 2'b01);
            tick();
        end
        idle_all();
        rst = 1'b1;
        sample();
        check_quiet("flush_rst");
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            check_quiet($sformatf("flush_post%0d", k));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mempool_l2_interleaver.md
Name: mempool_l2_interleaver

Overview:
- Multi-port, multi-bank L2 memory front end.
- Sits between NumPorts memory-request interfaces (one per AXI-to-memory converter) and NumBanks single-port SRAM macros.
- Replaces the single-port, single-bank L2 path.
- Word-interleaves addresses across banks and does per-bank round-robin arbitration.
- Tracks fixed-latency SRAM reads and returns responses in order per port; out-of-range accesses get an error response.

Parameters:
- NumPorts, 2, number of requesting ports (>=1)
- NumBanks, 4, number of SRAM banks (power of two, >=1)
- DataWidth, 64, data width in bits; strobe width is DataWidth/8
- AddrWidth, 32, request address width
- BankWords, 1024, words per bank (power of two)
- MemLatency, 1, SRAM read latency in cycles (>=1)
- BaseAddr, 32'h8000_0000, first byte address of the L2 window

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NumPorts  per-port request valid
- gnt_o  out  NumPorts  per-port grant; request consumed when req_i&gnt_o
- addr_i  in  NumPorts x AddrWidth  byte address
- we_i  in  NumPorts  1 = write
- wdata_i  in  NumPorts x DataWidth  write data
- strb_i  in  NumPorts x DataWidth/8  byte enables
- rvalid_o  out  NumPorts  response valid (reads and writes)
- rdata_o  out  NumPorts x DataWidth  read data ('0 for writes and errors)
- rerr_o  out  NumPorts  out-of-range response
- bank_req_o  out  NumBanks  SRAM request
- bank_we_o  out  NumBanks  SRAM write enable
- bank_addr_o  out  NumBanks x log2(BankWords)  SRAM row
- bank_wdata_o  out  NumBanks x DataWidth  SRAM write data
- bank_be_o  out  NumBanks x DataWidth/8  SRAM byte enables
- bank_rdata_i  in  NumBanks x DataWidth  SRAM read data, valid MemLatency cycles after bank_req_o

Behaviour:
- Clock and reset (already decided): one clock clk_i; reset rst_i is synchronous and active-high.
- Reset:
  - All outputs read 0 during and on the cycle after reset.
  - All round-robin pointers go to port 0 and all latency pipelines are cleared.
  - Requests and responses in flight at reset are dropped; no rvalid_o is issued for them.
- Address decode:
  - off = addr_i - BaseAddr (AddrWidth bits, unsigned wrap).
  - Word index w = off >> log2(DataWidth/8); bank = w mod NumBanks; row = (w / NumBanks) mod BankWords.
  - In range iff off < NumBanks*BankWords*DataWidth/8 (compute wide enough to avoid overflow).
  - Low address bits below the word offset are ignored.
- Arbitration (per bank, combinational, same cycle):
  - Candidates are ports with req_i=1, in-range, and decoded to this bank.
  - Winner is the first candidate at or after the bank's rr pointer, wrapping at NumPorts.
  - The pointer moves to winner+1 (mod NumPorts) only on a grant and holds otherwise.
  - NumPorts=1: no arbitration; grant is immediate.
- Grant:
  - gnt_o[p]=1 iff p wins its bank, or p is out-of-range.
  - Out-of-range requests are always granted the same cycle and never touch a bank.
  - gnt_o may depend combinationally on req_i/addr_i; req_i must not depend on gnt_o.
  - At most one grant per bank per cycle; different banks serve different ports in the same cycle.
- Bank drive:
  - bank_req_o=1 only for a granted bank; bank_we/addr/wdata/be come from the winning port.
  - Idle bank fields are 0.
- Response pipeline:
  - Per bank, a MemLatency-deep shift register of {valid, port id, we}.
  - Per port, a MemLatency-deep shift register of out-of-range {valid, we}.
  - Every granted request gives exactly one rvalid_o on its port exactly MemLatency cycles after grant.
  - Read: rdata_o = bank_rdata_i of that bank, rerr_o=0.
  - Write: rdata_o='0, rerr_o=0.
  - Out-of-range: rdata_o='0, rerr_o=1, for both reads and writes.
  - Fixed latency means responses on a port arrive in grant order; at most one response per port per cycle is guaranteed because each port is granted at most once per cycle.
- Throughput: one request per port per cycle with no conflicts; conflicting ports are served in round-robin order, one per cycle.
- A port holding req_i low between grants creates no bubbles on other ports.

Test Plan:
- Reset then idle: all outputs 0; apply rst_i for 1 cycle mid-traffic with 3 reads in flight -> no rvalid_o for them afterward.
- Port0 writes 64'hDEAD_BEEF_0000_0001, strb 8'hFF, to 0x8000_0008 (bank1 row0), then reads it back -> gnt same cycle; rvalid_o[0] after MemLatency; rdata_o matches; bank_req_o=4'b0010.
- Ports 0 and 1 both read bank2 (0x8000_0010 and 0x8000_0030), held for 4 cycles -> grants alternate 0,1,0,1 starting at port0; each rvalid_o arrives MemLatency after its own grant.
- Ports 0 and 1 access bank0 and bank3 in the same cycle -> both granted; bank_req_o=4'b1001; both rvalid_o fire together.
- Port1 reads 0x8000_8000 (first out-of-range byte for defaults) -> gnt_o[1]=1 immediately; rvalid_o[1] with rerr_o[1]=1 and rdata_o='0; bank_req_o=0.
- MemLatency=3, port0 issues 4 back-to-back reads to banks 0,1,2,3 -> 4 consecutive rvalid_o cycles starting 3 cycles after the first grant, data in issue order.
